apb_fnd_periph: RTL and testbench

- APB slave peripheral that drives a 4-digit, common-anode 7-segment (FND) display.
- It sits directly downstream of the APB master. It consumes one PSELx/PRDATAx/PREADYx slot of the bus, at a 4 KB window base such as 0x1000_1000.
- It holds three control registers and scans the four digits with a time-multiplexed digit counter.
- It inserts exactly one wait state per transfer.

---
 rtl/apb_fnd_if.sv | 26 ++
 rtl/apb_fnd_periph.sv | 127 ++++++++++++
 tb/tb_apb_fnd_periph.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/apb_fnd_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : apb_fnd_if
// Brief    : APB slot bundle (one PSELx/PRDATAx/PREADYx) for the FND peripheral
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface apb_fnd_if;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    output PRDATA, PREADY
  );
endinterface
`default_nettype wire

// File: rtl/apb_fnd_periph.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : apb_fnd_periph
// Brief    : APB slave with FCR/FDR/FPR registers driving a 4-digit 7-seg display
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module apb_fnd_periph #(
  parameter int SCAN_DIV = 100_000
) (
  input  logic       PCLK,
  input  logic       PRESET,
  apb_fnd_if.slave   bus,
  output logic [3:0] fnd_comm,
  output logic [7:0] fnd_font
);

  localparam int            c_CW   = $clog2(SCAN_DIV);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(SCAN_DIV - 1);

  logic            r_pready;
  logic [31:0]     r_prdata;
  logic            r_fcr;
  logic [13:0]     r_fdr;
  logic [3:0]      r_fpr;
  logic [c_CW-1:0] r_cnt;
  logic [1:0]      r_digit_sel;

  logic            w_access;
  logic [31:0]     w_rdata;
  logic [3:0]      w_d0;
  logic [3:0]      w_d1;
  logic [3:0]      w_d2;
  logic [3:0]      w_d3;
  logic [3:0]      w_dsel;

  // Gating with !PREADY keeps the completion cycle from starting a second access
  assign w_access   = bus.PSEL & bus.PENABLE & ~r_pready;
  assign bus.PREADY = r_pready;
  assign bus.PRDATA = r_prdata;

  always_comb begin
    w_rdata = 32'd0;
    case (bus.PADDR[3:2])
      2'd0:    w_rdata = {31'd0, r_fcr};
      2'd1:    w_rdata = {18'd0, r_fdr};
      2'd2:    w_rdata = {28'd0, r_fpr};
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_pready <= 1'b0;
      r_prdata <= 32'd0;
      r_fcr    <= 1'b0;
      r_fdr    <= 14'd0;
      r_fpr    <= 4'd0;
    end else begin
      r_pready <= w_access;
      if (w_access && bus.PWRITE) begin
        case (bus.PADDR[3:2])
          2'd0:    r_fcr <= bus.PWDATA[0];
          2'd1:    r_fdr <= bus.PWDATA[13:0];
          2'd2:    r_fpr <= bus.PWDATA[3:0];
          default: ;
        endcase
      end
      if (w_access && !bus.PWRITE) begin
        r_prdata <= w_rdata;
      end
    end
  end

  // Digit scan runs regardless of the display enable
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_cnt       <= '0;
      r_digit_sel <= 2'd0;
    end else if (r_cnt == c_LAST) begin
      r_cnt       <= '0;
      r_digit_sel <= r_digit_sel + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_d0 = 4'(r_fdr % 14'd10);
  assign w_d1 = 4'((r_fdr / 14'd10) % 14'd10);
  assign w_d2 = 4'((r_fdr / 14'd100) % 14'd10);
  assign w_d3 = 4'((r_fdr / 14'd1000) % 14'd10);

  always_comb begin
    case (r_digit_sel)
      2'd0:    w_dsel = w_d0;
      2'd1:    w_dsel = w_d1;
      2'd2:    w_dsel = w_d2;
      default: w_dsel = w_d3;
    endcase
  end

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'h40;
      4'd1:    f_seg = 7'h79;
      4'd2:    f_seg = 7'h24;
      4'd3:    f_seg = 7'h30;
      4'd4:    f_seg = 7'h19;
      4'd5:    f_seg = 7'h12;
      4'd6:    f_seg = 7'h02;
      4'd7:    f_seg = 7'h78;
      4'd8:    f_seg = 7'h00;
      4'd9:    f_seg = 7'h10;
      default: f_seg = 7'h7F;
    endcase
  endfunction

  always_comb begin
    fnd_comm = 4'hF;
    fnd_font = 8'hFF;
    if (r_fcr) begin
      fnd_comm = ~(4'b0001 << r_digit_sel);
      fnd_font = {~r_fpr[r_digit_sel], f_seg(w_dsel)};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_fnd_periph.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_apb_fnd_periph
// Brief    : Scoreboard bench for apb_fnd_periph (SCAN_DIV = 4)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_apb_fnd_periph;

  localparam int c_DIV = 4;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [3:0] fnd_comm;
  logic [7:0] fnd_font;

  apb_fnd_if bus ();

  apb_fnd_periph #(.SCAN_DIV(c_DIV)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .bus      (bus),
    .fnd_comm (fnd_comm),
    .fnd_font (fnd_font)
  );

  always #5 PCLK = ~PCLK;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int t0      = 0;
  logic [31:0] sb_q[$];

  logic [3:0] comm_tab [4]    = '{4'hE, 4'hD, 4'hB, 4'h7};
  // set 0: FDR=1234, FPR=0100 ; set 1: FDR=16383, FPR=0000
  logic [7:0] font_tab [2][4] = '{'{8'h99, 8'hB0, 8'h24, 8'hF9},
                                  '{8'hB0, 8'h80, 8'hB0, 8'h82}};

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Read data is compared against the scoreboard in the completion cycle
  always @(negedge PCLK) begin
    if (bus.PREADY && bus.PSEL && !bus.PWRITE) begin
      if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else                  check("rdata", bus.PRDATA, sb_q.pop_front());
    end
  end

  task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] data);
    int lat;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = data;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    lat = 0;
    do begin
      @(posedge PCLK); #1;
      lat++;
    end while (!bus.PREADY && lat < 8);
    check("ready_latency", 32'(lat), 32'd1);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    check("ready_single", {31'd0, bus.PREADY}, 32'd0);
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
    apb_xfer(1'b1, addr, data);
  endtask

  task automatic apb_read(input logic [3:0] addr, input logic [31:0] exp);
    sb_q.push_back(exp);
    apb_xfer(1'b0, addr, 32'd0);
  endtask

  task automatic check_display(input string tag, input int set);
    int sel;
    sel = ((cyc - t0) / c_DIV) % 4;
    check({tag, "_comm"}, {28'd0, fnd_comm}, {28'd0, comm_tab[sel]});
    check({tag, "_font"}, {24'd0, fnd_font}, {24'd0, font_tab[set][sel]});
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_comm"}, {28'd0, fnd_comm}, 32'h0000_000F);
    check({tag, "_font"}, {24'd0, fnd_font}, 32'h0000_00FF);
  endtask

  initial begin
    int n;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = 4'd0; bus.PWDATA = 32'd0;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    check("rst_pready", {31'd0, bus.PREADY}, 32'd0);
    check("rst_prdata", bus.PRDATA, 32'd0);
    check_blank("rst");
    apb_read(4'h0, 32'd0);
    apb_read(4'h4, 32'd0);
    apb_read(4'h8, 32'd0);

    apb_write(4'h4, 32'h0000_04D2);
    apb_read(4'h4, 32'h0000_04D2);
    // write must leave PRDATA untouched
    apb_write(4'h8, 32'h0000_0004);
    check("prdata_hold", bus.PRDATA, 32'h0000_04D2);

    // SETUP phase without ACCESS does nothing
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 4'h4; bus.PWDATA = 32'h1111;
    repeat (3) begin
      @(posedge PCLK); #1;
      check("setup_only_ready", {31'd0, bus.PREADY}, 32'd0);
    end
    bus.PSEL = 1'b0;
    apb_read(4'h4, 32'h0000_04D2);

    // FDR=1234, FPR=0100 already; enable and lock onto the digit-0 slot start
    apb_write(4'h0, 32'h1);
    n = 0;
    do begin @(negedge PCLK); n++; end while (fnd_comm == 4'hE && n < 40);
    do begin @(negedge PCLK); n++; end while (fnd_comm != 4'hE && n < 80);
    check("sync_timeout", 32'(n >= 80), 32'd0);
    t0 = cyc;
    repeat (16) begin check_display("scan1234", 0); @(negedge PCLK); end

    // overflow value, upper bits discarded on write
    apb_write(4'h4, 32'hFFFF_FFFF);
    apb_write(4'h8, 32'h0);
    apb_read(4'h4, 32'h0000_3FFF);
    repeat (16) begin check_display("scan16383", 1); @(negedge PCLK); end

    apb_write(4'h0, 32'h0);
    check_blank("disable");
    repeat (6) @(negedge PCLK);
    check_blank("disable_hold");
    apb_write(4'h0, 32'h1);
    repeat (8) begin check_display("reenable", 1); @(negedge PCLK); end

    apb_write(4'hC, 32'hFFFF_FFFF);
    apb_read(4'hC, 32'd0);
    apb_read(4'h0, 32'h1);
    apb_read(4'h4, 32'h0000_3FFF);
    apb_read(4'h8, 32'h0);

    // reset arrives together with the ACCESS phase of an FDR write
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 4'h4; bus.PWDATA = 32'h55;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("abort_ready", {31'd0, bus.PREADY}, 32'd0);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; PRESET = 1'b0;
    @(posedge PCLK); #1;
    check("abort_ready2", {31'd0, bus.PREADY}, 32'd0);
    check_blank("abort");
    apb_read(4'h4, 32'd0);
    apb_read(4'h0, 32'd0);

    repeat (2) @(posedge PCLK);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
